// File: rtl/vec_exec_pipe.sv
// vec_exec_pipe
// Execute stage of the filter GPU vector pipeline. Holds the Decode->Execute
// (E) and Execute->Memory (M) pipeline registers for LANES lanes of DW-bit
// pixels, resolves M/W operand forwarding, runs a per-lane ALU, keeps the
// NZCV flags taken from lane 0 and produces centre/neighbour addresses.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   STALL_E, FLUSH_E   hold E and bubble M / clear E (flush wins)
//   VALID_D .. DIRSRC_D decode-stage instruction fields
//   RESULT_W, WA3_W, REGWRITE_W   writeback forwarding source
//   VALID_M .. MEMTOREG_M         memory-stage register outputs
//   FLAGS              {N,Z,C,V}
module vec_exec_pipe #(
  parameter int LANES  = 3,
  parameter int DW     = 18,
  parameter int AW     = 10,
  parameter int STRIDE = 480
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                STALL_E,
  input  logic                FLUSH_E,
  input  logic                VALID_D,
  input  logic [LANES*DW-1:0] RD1_D,
  input  logic [LANES*DW-1:0] RD2_D,
  input  logic [DW-1:0]       IMM_D,
  input  logic [3:0]          RA1_D,
  input  logic [3:0]          RA2_D,
  input  logic [3:0]          WA3_D,
  input  logic [3:0]          ALUOP_D,
  input  logic                ALUSRC_D,
  input  logic                REGWRITE_D,
  input  logic                MEMWRITE_D,
  input  logic                MEMTOREG_D,
  input  logic                FLAGWRITE_D,
  input  logic                DIRSRC_D,
  input  logic [LANES*DW-1:0] RESULT_W,
  input  logic [3:0]          WA3_W,
  input  logic                REGWRITE_W,
  output logic                VALID_M,
  output logic [LANES*DW-1:0] ALURESULT_M,
  output logic [LANES*DW-1:0] WRITEDATA_M,
  output logic [AW-1:0]       ADDR_M,
  output logic [AW-1:0]       ADDRP_M,
  output logic [AW-1:0]       ADDRN_M,
  output logic [3:0]          WA3_M,
  output logic                REGWRITE_M,
  output logic                MEMWRITE_M,
  output logic                MEMTOREG_M,
  output logic [3:0]          FLAGS
);

  localparam int VW = LANES * DW;
  localparam logic [AW-1:0] STEP_ROW = AW'(STRIDE);
  localparam logic [AW-1:0] STEP_ONE = {{(AW-1){1'b0}}, 1'b1};

  // E register
  logic          r_valid_e;
  logic [VW-1:0] r_rd1_e;
  logic [VW-1:0] r_rd2_e;
  logic [DW-1:0] r_imm_e;
  logic [3:0]    r_ra1_e;
  logic [3:0]    r_ra2_e;
  logic [3:0]    r_wa3_e;
  logic [3:0]    r_aluop_e;
  logic          r_alusrc_e;
  logic          r_regwrite_e;
  logic          r_memwrite_e;
  logic          r_memtoreg_e;
  logic          r_flagwrite_e;
  logic          r_dirsrc_e;

  // M register and flags
  logic          r_valid_m;
  logic [VW-1:0] r_aluresult_m;
  logic [VW-1:0] r_writedata_m;
  logic [AW-1:0] r_addr_m;
  logic [AW-1:0] r_addrp_m;
  logic [AW-1:0] r_addrn_m;
  logic [3:0]    r_wa3_m;
  logic          r_regwrite_m;
  logic          r_memwrite_m;
  logic          r_memtoreg_m;
  logic [3:0]    r_flags;

  // Execute datapath
  logic          w_fwd_a_m;
  logic          w_fwd_a_w;
  logic          w_fwd_b_m;
  logic          w_fwd_b_w;
  logic [VW-1:0] w_src_a;
  logic [VW-1:0] w_src_b;
  logic [VW-1:0] w_op_b;
  logic [VW-1:0] w_alu;
  logic [DW-1:0] w_a0;
  logic [DW-1:0] w_b0;
  logic [DW-1:0] w_res0;
  logic          w_flag_c;
  logic          w_flag_v;
  logic [3:0]    w_flags;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_step;
  logic [AW-1:0] w_addrp;
  logic [AW-1:0] w_addrn;

  // One lane of the ALU; shifts use B[4:0] and saturate to 0 at >= DW.
  function automatic logic [DW-1:0] alu_lane(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [3:0]    op);
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0:    res = sum[DW-1:0];
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = b;
      4'd6:    res = (int'(b[4:0]) >= DW) ? {DW{1'b0}} : (a << b[4:0]);
      4'd7:    res = (int'(b[4:0]) >= DW) ? {DW{1'b0}} : (a >> b[4:0]);
      4'd8:    res = (a < b) ? a : b;
      4'd9:    res = (a > b) ? a : b;
      4'd10:   res = sum[DW:1];
      default: res = {DW{1'b0}};
    endcase
    return res;
  endfunction

  // Register 15 is never forwarded; an M match only counts for a live slot.
  assign w_fwd_a_m = r_regwrite_m & r_valid_m & (r_wa3_m == r_ra1_e) & (r_ra1_e != 4'd15);
  assign w_fwd_a_w = REGWRITE_W & (WA3_W == r_ra1_e) & (r_ra1_e != 4'd15);
  assign w_fwd_b_m = r_regwrite_m & r_valid_m & (r_wa3_m == r_ra2_e) & (r_ra2_e != 4'd15);
  assign w_fwd_b_w = REGWRITE_W & (WA3_W == r_ra2_e) & (r_ra2_e != 4'd15);

  // Source A forwarding mux, M has priority over W
  always_comb begin
    if (w_fwd_a_m) begin
      w_src_a = r_aluresult_m;
    end else if (w_fwd_a_w) begin
      w_src_a = RESULT_W;
    end else begin
      w_src_a = r_rd1_e;
    end
  end

  // Source B forwarding mux, M has priority over W
  always_comb begin
    if (w_fwd_b_m) begin
      w_src_b = r_aluresult_m;
    end else if (w_fwd_b_w) begin
      w_src_b = RESULT_W;
    end else begin
      w_src_b = r_rd2_e;
    end
  end

  // Per-lane B operand selection and ALU
  always_comb begin
    w_op_b = {VW{1'b0}};
    w_alu  = {VW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_op_b[i*DW +: DW] = r_alusrc_e ? r_imm_e : w_src_b[i*DW +: DW];
      w_alu[i*DW +: DW]  = alu_lane(w_src_a[i*DW +: DW], w_op_b[i*DW +: DW], r_aluop_e);
    end
  end

  assign w_a0   = w_src_a[DW-1:0];
  assign w_b0   = w_op_b[DW-1:0];
  assign w_res0 = w_alu[DW-1:0];

  // Lane-0 carry/overflow; an add carries out exactly when the wrapped sum is below A
  always_comb begin
    w_flag_c = 1'b0;
    w_flag_v = 1'b0;
    case (r_aluop_e)
      4'd0: begin
        w_flag_c = (w_res0 < w_a0);
        w_flag_v = (w_a0[DW-1] == w_b0[DW-1]) & (w_res0[DW-1] != w_a0[DW-1]);
      end
      4'd1: begin
        w_flag_c = (w_a0 >= w_b0);
        w_flag_v = (w_a0[DW-1] != w_b0[DW-1]) & (w_res0[DW-1] != w_a0[DW-1]);
      end
      default: begin
        w_flag_c = 1'b0;
        w_flag_v = 1'b0;
      end
    endcase
  end

  assign w_flags = {w_res0[DW-1], (w_res0 == {DW{1'b0}}), w_flag_c, w_flag_v};

  // Neighbour addresses wrap modulo 2^AW
  assign w_addr  = w_res0[AW-1:0];
  assign w_step  = r_dirsrc_e ? STEP_ROW : STEP_ONE;
  assign w_addrp = w_addr + w_step;
  assign w_addrn = w_addr - w_step;

  // Decode->Execute register: flush drops the incoming slot, stall holds E
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid_e     <= 1'b0;
      r_rd1_e       <= {VW{1'b0}};
      r_rd2_e       <= {VW{1'b0}};
      r_imm_e       <= {DW{1'b0}};
      r_ra1_e       <= 4'd0;
      r_ra2_e       <= 4'd0;
      r_wa3_e       <= 4'd0;
      r_aluop_e     <= 4'd0;
      r_alusrc_e    <= 1'b0;
      r_regwrite_e  <= 1'b0;
      r_memwrite_e  <= 1'b0;
      r_memtoreg_e  <= 1'b0;
      r_flagwrite_e <= 1'b0;
      r_dirsrc_e    <= 1'b0;
    end else if (FLUSH_E) begin
      r_valid_e     <= 1'b0;
      r_regwrite_e  <= 1'b0;
      r_memwrite_e  <= 1'b0;
      r_memtoreg_e  <= 1'b0;
      r_flagwrite_e <= 1'b0;
    end else if (!STALL_E) begin
      r_valid_e     <= VALID_D;
      r_rd1_e       <= RD1_D;
      r_rd2_e       <= RD2_D;
      r_imm_e       <= IMM_D;
      r_ra1_e       <= RA1_D;
      r_ra2_e       <= RA2_D;
      r_wa3_e       <= WA3_D;
      r_aluop_e     <= ALUOP_D;
      r_alusrc_e    <= ALUSRC_D;
      r_regwrite_e  <= REGWRITE_D;
      r_memwrite_e  <= MEMWRITE_D;
      r_memtoreg_e  <= MEMTOREG_D;
      r_flagwrite_e <= FLAGWRITE_D;
      r_dirsrc_e    <= DIRSRC_D;
    end
  end

  // Execute->Memory register: a stall loads a bubble and keeps the old data
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid_m     <= 1'b0;
      r_aluresult_m <= {VW{1'b0}};
      r_writedata_m <= {VW{1'b0}};
      r_addr_m      <= {AW{1'b0}};
      r_addrp_m     <= {AW{1'b0}};
      r_addrn_m     <= {AW{1'b0}};
      r_wa3_m       <= 4'd0;
      r_regwrite_m  <= 1'b0;
      r_memwrite_m  <= 1'b0;
      r_memtoreg_m  <= 1'b0;
    end else if (STALL_E) begin
      r_valid_m     <= 1'b0;
      r_regwrite_m  <= 1'b0;
      r_memwrite_m  <= 1'b0;
      r_memtoreg_m  <= 1'b0;
    end else begin
      r_valid_m     <= r_valid_e;
      r_aluresult_m <= w_alu;
      r_writedata_m <= w_src_b;
      r_addr_m      <= w_addr;
      r_addrp_m     <= w_addrp;
      r_addrn_m     <= w_addrn;
      r_wa3_m       <= r_wa3_e;
      r_regwrite_m  <= r_valid_e & r_regwrite_e;
      r_memwrite_m  <= r_valid_e & r_memwrite_e;
      r_memtoreg_m  <= r_valid_e & r_memtoreg_e;
    end
  end

  // NZCV register, written only when a live flag-setting op advances to M
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_flags <= 4'd0;
    end else if (r_valid_e & r_flagwrite_e & ~STALL_E) begin
      r_flags <= w_flags;
    end
  end

  assign VALID_M     = r_valid_m;
  assign ALURESULT_M = r_aluresult_m;
  assign WRITEDATA_M = r_writedata_m;
  assign ADDR_M      = r_addr_m;
  assign ADDRP_M     = r_addrp_m;
  assign ADDRN_M     = r_addrn_m;
  assign WA3_M       = r_wa3_m;
  assign REGWRITE_M  = r_regwrite_m;
  assign MEMWRITE_M  = r_memwrite_m;
  assign MEMTOREG_M  = r_memtoreg_m;
  assign FLAGS       = r_flags;

endmodule

// File: tb/tb_vec_exec_pipe.sv
// tb_vec_exec_pipe
// Self-checking bench for vec_exec_pipe: directed scenarios followed by
// randomized traffic, all compared against a behavioural pipeline model.
module tb_vec_exec_pipe;
  localparam int LANES  = 3;
  localparam int DW     = 18;
  localparam int AW     = 10;
  localparam int STRIDE = 480;
  localparam int VW     = LANES * DW;
  localparam longint MOD  = longint'(1) << DW;
  localparam longint HALF = MOD / 2;
  localparam longint AMOD = longint'(1) << AW;

  logic          CLK = 1'b0;
  logic          RST, STALL_E, FLUSH_E, VALID_D;
  logic [VW-1:0] RD1_D, RD2_D, RESULT_W;
  logic [DW-1:0] IMM_D;
  logic [3:0]    RA1_D, RA2_D, WA3_D, ALUOP_D, WA3_W;
  logic          ALUSRC_D, REGWRITE_D, MEMWRITE_D, MEMTOREG_D, FLAGWRITE_D, DIRSRC_D, REGWRITE_W;
  logic          VALID_M, REGWRITE_M, MEMWRITE_M, MEMTOREG_M;
  logic [VW-1:0] ALURESULT_M, WRITEDATA_M;
  logic [AW-1:0] ADDR_M, ADDRP_M, ADDRN_M;
  logic [3:0]    WA3_M, FLAGS;

  int n_checks = 0;
  int n_errors = 0;

  // Model: instruction waiting in E and expected M-stage contents
  logic          me_valid = 1'b0;
  logic [VW-1:0] me_rd1 = '0, me_rd2 = '0;
  logic [DW-1:0] me_imm = '0;
  logic [3:0]    me_ra1 = '0, me_ra2 = '0, me_wa3 = '0, me_op = '0;
  logic          me_alusrc = 1'b0, me_regw = 1'b0, me_memw = 1'b0, me_mtr = 1'b0, me_flagw = 1'b0, me_dir = 1'b0;
  logic          mm_valid = 1'b0, mm_regw = 1'b0, mm_memw = 1'b0, mm_mtr = 1'b0;
  logic [VW-1:0] mm_res = '0, mm_wd = '0;
  logic [AW-1:0] mm_addr = '0, mm_addrp = '0, mm_addrn = '0;
  logic [3:0]    mm_wa3 = '0, m_flags = '0;

  vec_exec_pipe #(.LANES(LANES), .DW(DW), .AW(AW), .STRIDE(STRIDE)) dut (
    .CLK(CLK), .RST(RST), .STALL_E(STALL_E), .FLUSH_E(FLUSH_E), .VALID_D(VALID_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .IMM_D(IMM_D), .RA1_D(RA1_D), .RA2_D(RA2_D),
    .WA3_D(WA3_D), .ALUOP_D(ALUOP_D), .ALUSRC_D(ALUSRC_D), .REGWRITE_D(REGWRITE_D),
    .MEMWRITE_D(MEMWRITE_D), .MEMTOREG_D(MEMTOREG_D), .FLAGWRITE_D(FLAGWRITE_D),
    .DIRSRC_D(DIRSRC_D), .RESULT_W(RESULT_W), .WA3_W(WA3_W), .REGWRITE_W(REGWRITE_W),
    .VALID_M(VALID_M), .ALURESULT_M(ALURESULT_M), .WRITEDATA_M(WRITEDATA_M),
    .ADDR_M(ADDR_M), .ADDRP_M(ADDRP_M), .ADDRN_M(ADDRN_M), .WA3_M(WA3_M),
    .REGWRITE_M(REGWRITE_M), .MEMWRITE_M(MEMWRITE_M), .MEMTOREG_M(MEMTOREG_M),
    .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack3(input logic [DW-1:0] l2, input logic [DW-1:0] l1, input logic [DW-1:0] l0);
    return {l2, l1, l0};
  endfunction

  // Reference ALU in plain integer arithmetic
  function automatic longint ref_alu(input longint a, input longint b, input int op);
    longint sh;
    sh = b % 32;
    case (op)
      0:  return (a + b) % MOD;
      1:  return (a - b + MOD) % MOD;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return b;
      6:  return (sh >= DW) ? 0 : (a * (longint'(1) << sh)) % MOD;
      7:  return (sh >= DW) ? 0 : a / (longint'(1) << sh);
      8:  return (a < b) ? a : b;
      9:  return (a > b) ? a : b;
      10: return (a + b) / 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input longint a, input longint b, input int op, input longint r);
    logic n, z, c, v;
    longint sa, sb, s;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    n = (r >= HALF);
    z = (r == 0);
    c = 1'b0;
    v = 1'b0;
    if (op == 0) begin
      s = sa + sb;
      c = ((a + b) >= MOD);
      v = (s >= HALF) || (s < -HALF);
    end else if (op == 1) begin
      s = sa - sb;
      c = (a >= b);
      v = (s >= HALF) || (s < -HALF);
    end
    return {n, z, c, v};
  endfunction

  function automatic logic [VW-1:0] fwd(input logic [3:0] ra, input logic [VW-1:0] ev);
    if (ra != 4'd15 && mm_valid && mm_regw && mm_wa3 == ra) return mm_res;
    if (ra != 4'd15 && REGWRITE_W && WA3_W == ra) return RESULT_W;
    return ev;
  endfunction

  // Advance model and DUT by one edge, then compare
  task automatic step();
    logic [VW-1:0] a_v, b2_v, res_v;
    logic [3:0] fl;
    longint a, b, r, r0, st;
    bit was_rst;
    a_v   = fwd(me_ra1, me_rd1);
    b2_v  = fwd(me_ra2, me_rd2);
    res_v = '0;
    fl    = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      a = longint'(a_v[i*DW +: DW]);
      b = me_alusrc ? longint'(me_imm) : longint'(b2_v[i*DW +: DW]);
      r = ref_alu(a, b, int'(me_op));
      res_v[i*DW +: DW] = DW'(r);
      if (i == 0) fl = ref_flags(a, b, int'(me_op), r);
    end
    st = me_dir ? STRIDE : 1;
    r0 = longint'(res_v[DW-1:0]) % AMOD;
    was_rst = RST;
    if (RST) begin
      me_valid = 0; me_rd1 = '0; me_rd2 = '0; me_imm = '0; me_ra1 = '0; me_ra2 = '0; me_wa3 = '0;
      me_op = '0; me_alusrc = 0; me_regw = 0; me_memw = 0; me_mtr = 0; me_flagw = 0; me_dir = 0;
      mm_valid = 0; mm_regw = 0; mm_memw = 0; mm_mtr = 0; mm_res = '0; mm_wd = '0;
      mm_addr = '0; mm_addrp = '0; mm_addrn = '0; mm_wa3 = '0; m_flags = '0;
    end else begin
      if (STALL_E) begin
        mm_valid = 0; mm_regw = 0; mm_memw = 0; mm_mtr = 0;
      end else begin
        mm_valid = me_valid;
        mm_res   = res_v;
        mm_wd    = b2_v;
        mm_addr  = AW'(r0);
        mm_addrp = AW'((r0 + st) % AMOD);
        mm_addrn = AW'((r0 - st + AMOD) % AMOD);
        mm_wa3   = me_wa3;
        mm_regw  = me_valid & me_regw;
        mm_memw  = me_valid & me_memw;
        mm_mtr   = me_valid & me_mtr;
        if (me_valid && me_flagw) m_flags = fl;
      end
      if (FLUSH_E) begin
        me_valid = 0;
      end else if (!STALL_E) begin
        me_valid = VALID_D; me_rd1 = RD1_D; me_rd2 = RD2_D; me_imm = IMM_D;
        me_ra1 = RA1_D; me_ra2 = RA2_D; me_wa3 = WA3_D; me_op = ALUOP_D;
        me_alusrc = ALUSRC_D; me_regw = REGWRITE_D; me_memw = MEMWRITE_D;
        me_mtr = MEMTOREG_D; me_flagw = FLAGWRITE_D; me_dir = DIRSRC_D;
      end
    end
    @(posedge CLK);
    #1;
    check_eq("valid_m", 64'(VALID_M), 64'(mm_valid));
    check_eq("regwrite_m", 64'(REGWRITE_M), 64'(mm_regw));
    check_eq("memwrite_m", 64'(MEMWRITE_M), 64'(mm_memw));
    check_eq("memtoreg_m", 64'(MEMTOREG_M), 64'(mm_mtr));
    check_eq("flags", 64'(FLAGS), 64'(m_flags));
    if (mm_valid || was_rst) begin
      check_eq("aluresult_m", 64'(ALURESULT_M), 64'(mm_res));
      check_eq("writedata_m", 64'(WRITEDATA_M), 64'(mm_wd));
      check_eq("addr_m", 64'(ADDR_M), 64'(mm_addr));
      check_eq("addrp_m", 64'(ADDRP_M), 64'(mm_addrp));
      check_eq("addrn_m", 64'(ADDRN_M), 64'(mm_addrn));
      check_eq("wa3_m", 64'(WA3_M), 64'(mm_wa3));
    end
  endtask

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: begin v = '0; v[DW-1] = 1'b1; end
      3: v = DW'($urandom_range(0, 40));
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic rand_inputs();
    RST     = ($urandom_range(0, 99) < 2);
    STALL_E = ($urandom_range(0, 9) == 0);
    FLUSH_E = ($urandom_range(0, 9) == 0);
    VALID_D = ($urandom_range(0, 9) != 0);
    for (int i = 0; i < LANES; i++) begin
      RD1_D[i*DW +: DW]    = rnd_val();
      RD2_D[i*DW +: DW]    = rnd_val();
      RESULT_W[i*DW +: DW] = rnd_val();
    end
    IMM_D       = rnd_val();
    RA1_D       = rnd_reg();
    RA2_D       = rnd_reg();
    WA3_D       = rnd_reg();
    WA3_W       = rnd_reg();
    ALUOP_D     = 4'($urandom_range(0, 15));
    ALUSRC_D    = 1'($urandom_range(0, 1));
    REGWRITE_D  = 1'($urandom_range(0, 1));
    MEMWRITE_D  = 1'($urandom_range(0, 1));
    MEMTOREG_D  = 1'($urandom_range(0, 1));
    FLAGWRITE_D = 1'($urandom_range(0, 1));
    DIRSRC_D    = 1'($urandom_range(0, 1));
    REGWRITE_W  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    RST = 0; STALL_E = 0; FLUSH_E = 0; VALID_D = 0; REGWRITE_W = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] wa3, input logic [VW-1:0] rd1, input logic [VW-1:0] rd2,
                       input logic [DW-1:0] imm, input logic alusrc, input logic regw,
                       input logic flagw, input logic dir);
    idle();
    VALID_D = 1; ALUOP_D = op; RA1_D = ra1; RA2_D = ra2; WA3_D = wa3;
    RD1_D = rd1; RD2_D = rd2; IMM_D = imm; ALUSRC_D = alusrc; REGWRITE_D = regw;
    MEMWRITE_D = 0; MEMTOREG_D = 0; FLAGWRITE_D = flagw; DIRSRC_D = dir;
  endtask

  initial begin
    rand_inputs();
    // Reset held two cycles with random inputs
    RST = 1; step();
    rand_inputs(); RST = 1; step();
    check_eq("rst_valid", 64'(VALID_M), 64'd0);
    check_eq("rst_flags", 64'(FLAGS), 64'd0);
    check_eq("rst_result", 64'(ALURESULT_M), 64'd0);

    // ADD with lane-2 wrap
    issue(4'd0, 4'd1, 4'd2, 4'd3, pack3(18'h3FFFF, 18'd7, 18'd5), pack3(18'd1, 18'd1, 18'd3), 18'd0, 0, 1, 1, 0);
    step(); idle(); step();
    check_eq("add_result", 64'(ALURESULT_M), 64'(pack3(18'd0, 18'd8, 18'd8)));
    check_eq("add_flags", 64'(FLAGS), 64'd0);

    // SUB flags: equal then negative
    issue(4'd1, 4'd4, 4'd5, 4'd6, pack3(18'd0, 18'd0, 18'd5), pack3(18'd0, 18'd0, 18'd5), 18'd0, 0, 0, 1, 0);
    step();
    issue(4'd1, 4'd4, 4'd5, 4'd6, pack3(18'd0, 18'd0, 18'd3), pack3(18'd0, 18'd0, 18'd5), 18'd0, 0, 0, 1, 0);
    step();
    check_eq("sub_eq_flags", 64'(FLAGS), 64'b0110);
    idle(); step();
    check_eq("sub_neg_res", 64'(ALURESULT_M[DW-1:0]), 64'h3FFFE);
    check_eq("sub_neg_flags", 64'(FLAGS), 64'b1000);

    // Back-to-back forwarding from M, with a conflicting W match
    issue(4'd5, 4'd0, 4'd0, 4'd2, pack3(18'd3, 18'd3, 18'd3), pack3(18'd4, 18'd4, 18'd4), 18'd10, 1, 1, 0, 0);
    step();
    issue(4'd0, 4'd2, 4'd2, 4'd7, pack3(18'd1, 18'd1, 18'd1), pack3(18'd2, 18'd2, 18'd2), 18'd0, 0, 1, 0, 0);
    step();
    idle(); REGWRITE_W = 1; WA3_W = 4'd2; RESULT_W = pack3(18'd99, 18'd99, 18'd99);
    step();
    check_eq("fwd_m_result", 64'(ALURESULT_M), 64'(pack3(18'd20, 18'd20, 18'd20)));
    check_eq("fwd_m_wdata", 64'(WRITEDATA_M), 64'(pack3(18'd10, 18'd10, 18'd10)));

    // Forwarding through W after one bubble
    issue(4'd5, 4'd0, 4'd0, 4'd2, pack3(18'd3, 18'd3, 18'd3), pack3(18'd4, 18'd4, 18'd4), 18'd10, 1, 1, 0, 0);
    step(); idle(); step();
    issue(4'd0, 4'd2, 4'd2, 4'd7, pack3(18'd1, 18'd1, 18'd1), pack3(18'd2, 18'd2, 18'd2), 18'd0, 0, 1, 0, 0);
    step();
    idle(); REGWRITE_W = 1; WA3_W = 4'd2; RESULT_W = pack3(18'd10, 18'd10, 18'd10);
    step();
    check_eq("fwd_w_result", 64'(ALURESULT_M), 64'(pack3(18'd20, 18'd20, 18'd20)));

    // Address generation
    issue(4'd5, 4'd0, 4'd0, 4'd8, '0, '0, 18'd100, 1, 0, 0, 1);
    step(); idle(); step();
    check_eq("addr_row", 64'(ADDR_M), 64'd100);
    check_eq("addrp_row", 64'(ADDRP_M), 64'd580);
    check_eq("addrn_row", 64'(ADDRN_M), 64'd644);
    issue(4'd5, 4'd0, 4'd0, 4'd8, '0, '0, 18'd100, 1, 0, 0, 0);
    step(); idle(); step();
    check_eq("addrp_col", 64'(ADDRP_M), 64'd101);
    check_eq("addrn_col", 64'(ADDRN_M), 64'd99);
    issue(4'd5, 4'd0, 4'd0, 4'd8, '0, '0, 18'd1023, 1, 0, 0, 0);
    step(); idle(); step();
    check_eq("addrp_wrap", 64'(ADDRP_M), 64'd0);
    check_eq("addrn_top", 64'(ADDRN_M), 64'd1022);

    // Single-cycle stall
    issue(4'd5, 4'd0, 4'd0, 4'd9, '0, '0, 18'd7, 1, 0, 1, 0);
    step();
    idle(); STALL_E = 1; step();
    check_eq("stall_bubble", 64'(VALID_M), 64'd0);
    idle(); step();
    check_eq("stall_done", 64'(VALID_M), 64'd1);
    check_eq("stall_result", 64'(ALURESULT_M), 64'(pack3(18'd7, 18'd7, 18'd7)));
    idle(); step();
    check_eq("stall_once", 64'(VALID_M), 64'd0);

    // Stall together with flush loses the instruction and its flags
    issue(4'd5, 4'd0, 4'd0, 4'd9, '0, '0, 18'd0, 1, 0, 1, 0);
    step();
    idle(); STALL_E = 1; FLUSH_E = 1; step();
    check_eq("sf_bubble", 64'(VALID_M), 64'd0);
    idle(); step();
    check_eq("sf_lost", 64'(VALID_M), 64'd0);
    check_eq("sf_flags", 64'(FLAGS), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
